instruction_encoder: RTL and testbench
======================================

Name: instruction_encoder

Overview:
- Write-side counterpart of the instruction field decoder. Accepts decoded instruction fields over a valid/ready handshake and packs them into a 32-bit instruction word. The packing uses exactly the bit positions the decoder extracts from.
- Streams packed words into instruction memory at consecutive addresses starting from BASE.
- Used by the program loader and the test harness to fill each core's instruction memory.

Parameters:
- AW, 10, memory address width.
- DEPTH, 16, maximum words written per session (1..2^AW).
- BASE, 0, first write address; BASE+DEPTH-1 must be < 2^AW.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  pulse: open a session (count cleared, state RUN)
- stop  in  1  pulse: end session early (drain, then IDLE)
- in_valid  in  1  fields valid
- in_ready  out  1  encoder accepts fields this cycle
- opcode  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12] (all formats except U/J/default)
- funct7  in  7  R-type [31:25]
- i7  in  7  shift/S/B upper field [31:25]
- i5  in  5  shift amount [24:20], or S/B low field [11:7]
- s1  in  5  rs1 [19:15]
- s2  in  5  rs2 [24:20]
- de  in  5  rd [11:7]
- i12  in  12  I-type immediate [31:20]
- address  in  20  U/J field [31:12]
- mem_we  out  1  write request
- mem_addr  out  AW  write address = BASE + count (mod 2^AW)
- mem_wdata  out  32  packed instruction
- mem_ready  in  1  memory accepts write this cycle
- count  out  AW+1  words written this session
- full  out  1  count == DEPTH
- done  out  1  one-cycle pulse at session end (FULL entry or drain complete)

Behaviour:
- Packing: combinational from the inputs, registered on accept.
  - Format precedence follows the decoder exactly.
  - R (0110011): funct7|s2|s1|funct3|de|opcode.
  - Shift (0010011 with funct3 001 or 101): i7|i5|s1|funct3|de|opcode.
  - I (0010011 other funct3, 1100111, 0000011, 1111110): i12|s1|funct3|de|opcode.
  - S/B (1100011, 0100011, 1111111): i7|s2|s1|funct3|i5|opcode.
  - U/J (0110111, 0010111, 1101111) and every other opcode: address|de|opcode.
  - Fields not used by the selected format are ignored. No immediate bit scrambling is applied.
- Holding register: hold_valid plus hold_word. mem_we = hold_valid. mem_wdata = hold_word.
- Accept (in_valid & in_ready): loads hold_word and sets hold_valid, with 1-cycle latency to mem_we.
- Write completes on mem_we & mem_ready. On completion: count+1 and hold_valid cleared, unless a new accept happens in the same cycle.
- Back-to-back: with mem_ready held high, one word is written per cycle.
- in_ready = (state==RUN) & (hold_valid ? (mem_ready & count+1 < DEPTH) : (count < DEPTH)).
  - in_ready is never 1 when an accept would exceed DEPTH words.
  - mem_we stays high and hold_word stays stable until mem_ready.
- FSM states: IDLE, RUN, DRAIN, FULL.
  - IDLE: in_ready=0. start -> RUN with count=0.
  - RUN: the write completion that makes count==DEPTH -> FULL, done=1. stop -> DRAIN.
  - DRAIN: in_ready=0. If hold_valid=0 (immediately or after the pending write completes) -> IDLE, done=1.
  - FULL: in_ready=0, full=1. start -> RUN with count=0. stop is ignored.
- Simultaneous events:
  - start and stop in the same cycle: start wins.
  - start in RUN or DRAIN: ignored.
  - stop in RUN with count reaching DEPTH in the same cycle: FULL wins.
- Reset (any state, mid-write included), next edge:
  - state=IDLE, hold_valid=0, count=0.
  - mem_we=0, mem_addr=BASE, mem_wdata=0.
  - in_ready=0, full=0, done=0.
  - A pending write is dropped.

Test Plan:
1. Reset, start, one word each with mem_ready=1, expected mem_wdata at addresses 0..4:
   - ADD: opcode 0110011, funct7 0, s2 2, s1 1, funct3 0, de 3 -> 0x002081B3.
   - SLLI: opcode 0010011, funct3 001, i7 0, i5 5, s1 1, de 2 -> 0x00509113.
   - LW: opcode 0000011, i12 0x004, s1 2, funct3 010, de 5 -> 0x00412283.
   - SW: opcode 0100011, i7 0, s2 5, s1 2, funct3 010, i5 8 -> 0x00512423.
   - LUI: opcode 0110111, address 0x12345, de 1, garbage funct3/s1 -> 0x123450B7.
2. Backpressure: hold mem_ready=0 for 3 cycles. mem_we, mem_addr and mem_wdata stay stable; in_ready=0; count is unchanged until mem_ready=1.
3. Fill: DEPTH=16 with continuous in_valid. Exactly 16 writes at 0..15, then in_ready=0, full=1, a done pulse, and no 17th mem_we. A second start writes again from address 0.
4. stop with a word pending and mem_ready=0: state DRAIN, in_ready=0. After mem_ready=1: one write, then IDLE with a done pulse. count holds its final value.
5. Reset mid-write with mem_we=1: next cycle all outputs are at reset values and the pending word is never written.
6. start and stop asserted together in IDLE -> RUN. stop alone in IDLE -> no effect, no done.

Source files
------------

// File: rtl/instruction_encoder.sv
// Packs decoded instruction fields into 32-bit words and streams them
// into instruction memory at consecutive addresses from BASE.
module instruction_encoder #(
    parameter int AW    = 10,
    parameter int DEPTH = 16,
    parameter int BASE  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [6:0]    opcode,
    input  logic [2:0]    funct3,
    input  logic [6:0]    funct7,
    input  logic [6:0]    i7,
    input  logic [4:0]    i5,
    input  logic [4:0]    s1,
    input  logic [4:0]    s2,
    input  logic [4:0]    de,
    input  logic [11:0]   i12,
    input  logic [19:0]   address,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ready,
    output logic [AW:0]   count,
    output logic          full,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FULL
    } state_t;

    localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LP_BASE  = AW'(BASE);

    state_t        r_state;
    state_t        w_next;
    logic          r_hold_valid;
    logic [31:0]   r_hold_word;
    logic [AW:0]   r_count;
    logic          r_done;

    logic          w_is_r;
    logic          w_is_sh;
    logic          w_is_i;
    logic          w_is_sb;
    logic [31:0]   w_word;
    logic          w_accept;
    logic          w_complete;
    logic          w_open;
    logic          w_done;
    logic          w_in_ready;
    logic [AW:0]   w_count_p1;

    // Format classes are mutually exclusive, matching decoder precedence
    always_comb begin
        w_is_r  = (opcode == 7'b0110011);
        w_is_sh = (opcode == 7'b0010011) &&
                  ((funct3 == 3'b001) || (funct3 == 3'b101));
        w_is_i  = ((opcode == 7'b0010011) && !w_is_sh) ||
                  (opcode == 7'b1100111) ||
                  (opcode == 7'b0000011) ||
                  (opcode == 7'b1111110);
        w_is_sb = (opcode == 7'b1100011) ||
                  (opcode == 7'b0100011) ||
                  (opcode == 7'b1111111);
    end

    always_comb begin
        w_word = {address, de, opcode};
        unique case (1'b1)
            w_is_r:  w_word = {funct7, s2, s1, funct3, de, opcode};
            w_is_sh: w_word = {i7, i5, s1, funct3, de, opcode};
            w_is_i:  w_word = {i12, s1, funct3, de, opcode};
            w_is_sb: w_word = {i7, s2, s1, funct3, i5, opcode};
            default: w_word = {address, de, opcode};
        endcase
    end

    assign w_count_p1 = r_count + (AW+1)'(1);
    assign w_complete = r_hold_valid & mem_ready;
    assign w_accept   = in_valid & w_in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_open = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                    w_open = 1'b1;
                end
            end
            S_RUN: begin
                if (w_complete && (w_count_p1 == LP_DEPTH)) begin
                    w_next = S_FULL;
                    w_done = 1'b1;
                end else if (stop) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave once nothing is pending after this cycle's write
                if (!r_hold_valid || mem_ready) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end
            end
            S_FULL: begin
                if (start) begin
                    w_next = S_RUN;
                    w_open = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        if (r_state == S_RUN) begin
            if (r_hold_valid) begin
                w_in_ready = mem_ready && (w_count_p1 < LP_DEPTH);
            end else begin
                w_in_ready = (r_count < LP_DEPTH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_valid <= 1'b0;
            r_hold_word  <= '0;
            r_count      <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_done;
            if (w_accept) begin
                r_hold_valid <= 1'b1;
                r_hold_word  <= w_word;
            end else if (w_complete) begin
                r_hold_valid <= 1'b0;
            end
            if (w_open) begin
                r_count <= '0;
            end else if (w_complete) begin
                r_count <= w_count_p1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign mem_we    = r_hold_valid;
    assign mem_wdata = r_hold_word;
    assign mem_addr  = LP_BASE + r_count[AW-1:0];
    assign count     = r_count;
    assign full      = (r_count == LP_DEPTH);
    assign done      = r_done;

endmodule

// File: tb/tb_instruction_encoder.sv
// Randomised bench for instruction_encoder with a transaction-level
// model (accepted-word queue, session mode, written-word count).
module tb_instruction_encoder;

    localparam int AW    = 10;
    localparam int DEPTH = 16;
    localparam int BASE  = 0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [6:0]    opcode = '0;
    logic [2:0]    funct3 = '0;
    logic [6:0]    funct7 = '0;
    logic [6:0]    i7 = '0;
    logic [4:0]    i5 = '0;
    logic [4:0]    s1 = '0;
    logic [4:0]    s2 = '0;
    logic [4:0]    de = '0;
    logic [11:0]   i12 = '0;
    logic [19:0]   address = '0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready = 1'b0;
    logic [AW:0]   count;
    logic          full;
    logic          done;

    instruction_encoder #(.AW(AW), .DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .i7(i7), .i5(i5), .s1(s1), .s2(s2), .de(de),
        .i12(i12), .address(address),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .count(count), .full(full), .done(done)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;
    int          n_done_seen = 0;

    // Model: 0 idle, 1 run, 2 drain, 3 full
    int          m_mode = 0;
    logic [31:0] m_q[$];
    int          m_count = 0;
    logic [31:0] m_wdata = '0;
    bit          m_done = 1'b0;

    logic [31:0] log_d[$];
    int          log_a[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic logic [31:0] ref_pack(
        input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
        input logic [6:0] u7, input logic [4:0] l5, input logic [4:0] r1,
        input logic [4:0] r2, input logic [4:0] rd, input logic [11:0] im,
        input logic [19:0] ad);
        logic [31:0] w;
        bit r, sh, i, sb;
        r  = (op == 7'h33);
        sh = (op == 7'h13) && (f3 == 3'd1 || f3 == 3'd5);
        i  = ((op == 7'h13) && !sh) || op == 7'h67 || op == 7'h03 ||
             op == 7'h7E;
        sb = (op == 7'h63) || (op == 7'h23) || (op == 7'h7F);
        w = 32'(op);
        if (r)
            w = w | (32'(f7) << 25) | (32'(r2) << 20) | (32'(r1) << 15) |
                (32'(f3) << 12) | (32'(rd) << 7);
        else if (sh)
            w = w | (32'(u7) << 25) | (32'(l5) << 20) | (32'(r1) << 15) |
                (32'(f3) << 12) | (32'(rd) << 7);
        else if (i)
            w = w | (32'(im) << 20) | (32'(r1) << 15) |
                (32'(f3) << 12) | (32'(rd) << 7);
        else if (sb)
            w = w | (32'(u7) << 25) | (32'(r2) << 20) | (32'(r1) << 15) |
                (32'(f3) << 12) | (32'(l5) << 7);
        else
            w = w | (32'(ad) << 12) | (32'(rd) << 7);
        return w;
    endfunction

    // Compare, log, then advance the model with this cycle's inputs
    always @(negedge clk) begin
        bit exp_rdy;
        bit acc;
        bit cmp;
        logic [31:0] w;
        exp_rdy = (m_mode == 1) &&
                  ((m_q.size() > 0) ? (mem_ready && (m_count + 1 < DEPTH))
                                    : (m_count < DEPTH));
        if (chk_en) begin
            chk("mem_we", 32'(mem_we), 32'(m_q.size() > 0));
            chk("mem_addr", 32'(mem_addr),
                32'((BASE + m_count) % (1 << AW)));
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("count", 32'(count), 32'(m_count));
            chk("full", 32'(full), 32'(m_count == DEPTH));
            chk("done", 32'(done), 32'(m_done));
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            if (done === 1'b1) n_done_seen++;
            if (rst_n && mem_we === 1'b1 && mem_ready) begin
                log_d.push_back(mem_wdata);
                log_a.push_back(int'(mem_addr));
            end
        end
        if (!rst_n) begin
            m_mode = 0;
            m_q.delete();
            m_count = 0;
            m_wdata = '0;
            m_done = 1'b0;
        end else begin
            acc = in_valid && exp_rdy;
            cmp = (m_q.size() > 0) && mem_ready;
            m_done = 1'b0;
            if (cmp) begin
                void'(m_q.pop_front());
                m_count++;
            end
            if (acc) begin
                w = ref_pack(opcode, funct3, funct7, i7, i5, s1, s2, de,
                             i12, address);
                m_q.push_back(w);
                m_wdata = w;
            end
            if (start && (m_mode == 0 || m_mode == 3)) begin
                m_mode = 1;
                m_count = 0;
            end else if (m_mode == 1) begin
                if (cmp && m_count == DEPTH) begin
                    m_mode = 3;
                    m_done = 1'b1;
                end else if (stop) begin
                    m_mode = 2;
                end
            end else if (m_mode == 2 && m_q.size() == 0) begin
                m_mode = 0;
                m_done = 1'b1;
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(
        input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
        input logic [6:0] u7, input logic [4:0] l5, input logic [4:0] r1,
        input logic [4:0] r2, input logic [4:0] rd, input logic [11:0] im,
        input logic [19:0] ad);
        opcode = op; funct3 = f3; funct7 = f7; i7 = u7; i5 = l5;
        s1 = r1; s2 = r2; de = rd; i12 = im; address = ad;
    endtask

    task automatic rand_fields();
        logic [6:0] op;
        case ($urandom % 14)
            0: op = 7'h33;   1: op = 7'h13;   2: op = 7'h67;
            3: op = 7'h03;   4: op = 7'h7E;   5: op = 7'h63;
            6: op = 7'h23;   7: op = 7'h7F;   8: op = 7'h37;
            9: op = 7'h17;   10: op = 7'h6F;  11: op = 7'h13;
            default: op = 7'($urandom);
        endcase
        load(op, 3'($urandom), 7'($urandom), 7'($urandom), 5'($urandom),
             5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom),
             20'($urandom));
    endtask

    logic [31:0] t1_exp[5];
    int d0;

    initial begin
        t1_exp[0] = 32'h002081B3;
        t1_exp[1] = 32'h00509113;
        t1_exp[2] = 32'h00412283;
        t1_exp[3] = 32'h00512423;
        t1_exp[4] = 32'h123450B7;

        rst_n = 1'b0;
        cyc(2);
        chk_en = 1'b1;
        rst_n = 1'b1;
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);

        // stop alone in IDLE, then start+stop together
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        cyc();
        chk("idle_stop_done", 32'(n_done_seen), 32'd0);
        chk("idle_stop_rdy", 32'(in_ready), 32'd0);
        start = 1'b1;
        stop = 1'b1;
        cyc();
        start = 1'b0;
        stop = 1'b0;
        chk("startstop_run", 32'(in_ready), 32'd1);

        // Five literal encodings, back to back
        log_d.delete();
        log_a.delete();
        mem_ready = 1'b1;
        in_valid = 1'b1;
        load(7'h33, 3'd0, 7'h00, 7'h55, 5'd9, 5'd1, 5'd2, 5'd3, 12'hABC,
             20'hFFFFF);
        cyc();
        load(7'h13, 3'd1, 7'h7F, 7'h00, 5'd5, 5'd1, 5'd31, 5'd2, 12'hFFF,
             20'hFFFFF);
        cyc();
        load(7'h03, 3'd2, 7'h7F, 7'h7F, 5'd31, 5'd2, 5'd31, 5'd5, 12'h004,
             20'hFFFFF);
        cyc();
        load(7'h23, 3'd2, 7'h7F, 7'h00, 5'd8, 5'd2, 5'd5, 5'd31, 12'hFFF,
             20'hFFFFF);
        cyc();
        load(7'h37, 3'd7, 7'h7F, 7'h7F, 5'd31, 5'd31, 5'd31, 5'd1, 12'hFFF,
             20'h12345);
        cyc();
        in_valid = 1'b0;
        cyc(3);
        chk("t1_nwrites", 32'(log_d.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < log_d.size()) begin
                chk($sformatf("t1_word%0d", i), log_d[i], t1_exp[i]);
                chk($sformatf("t1_addr%0d", i), 32'(log_a[i]), 32'(i));
            end
        end

        // Backpressure for three cycles
        mem_ready = 1'b0;
        load(7'h33, 3'd0, 7'h00, 7'h00, 5'd0, 5'd1, 5'd2, 5'd3, 12'h0, 20'h0);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_we", 32'(mem_we), 32'd1);
            chk("bp_addr", 32'(mem_addr), 32'd5);
            chk("bp_wdata", mem_wdata, 32'h002081B3);
            chk("bp_rdy", 32'(in_ready), 32'd0);
            chk("bp_count", 32'(count), 32'd5);
            cyc();
        end
        mem_ready = 1'b1;
        cyc();
        chk("bp_count_after", 32'(count), 32'd6);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        cyc(2);

        // Fill to DEPTH
        log_d.delete();
        log_a.delete();
        d0 = n_done_seen;
        start = 1'b1;
        cyc();
        start = 1'b0;
        in_valid = 1'b1;
        mem_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            rand_fields();
            cyc();
            if (full === 1'b1) break;
        end
        cyc(3);
        in_valid = 1'b0;
        chk("fill_nwrites", 32'(log_a.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++)
            if (i < log_a.size())
                chk($sformatf("fill_addr%0d", i), 32'(log_a[i]), 32'(i));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'(DEPTH));
        chk("fill_rdy", 32'(in_ready), 32'd0);
        chk("fill_done", 32'(n_done_seen - d0), 32'd1);
        log_d.delete();
        log_a.delete();
        start = 1'b1;
        cyc();
        start = 1'b0;
        in_valid = 1'b1;
        rand_fields();
        cyc();
        in_valid = 1'b0;
        cyc(2);
        chk("restart_n", 32'(log_a.size()), 32'd1);
        if (log_a.size() > 0) chk("restart_addr", 32'(log_a[0]), 32'd0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        cyc(2);

        // stop while a word is pending
        start = 1'b1;
        cyc();
        start = 1'b0;
        mem_ready = 1'b0;
        in_valid = 1'b1;
        rand_fields();
        cyc();
        in_valid = 1'b0;
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("drain_rdy", 32'(in_ready), 32'd0);
        chk("drain_we", 32'(mem_we), 32'd1);
        cyc(2);
        chk("drain_we_held", 32'(mem_we), 32'd1);
        mem_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (done === 1'b1) break;
        end
        chk("drain_done", 32'(done), 32'd1);
        cyc();
        chk("drain_count", 32'(count), 32'd1);
        chk("drain_done_pulse", 32'(done), 32'd0);

        // Reset mid-write
        log_d.delete();
        log_a.delete();
        start = 1'b1;
        cyc();
        start = 1'b0;
        mem_ready = 1'b0;
        in_valid = 1'b1;
        rand_fields();
        cyc();
        in_valid = 1'b0;
        chk("mid_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        cyc();
        chk("mrst_we", 32'(mem_we), 32'd0);
        chk("mrst_addr", 32'(mem_addr), 32'(BASE));
        chk("mrst_wdata", mem_wdata, 32'd0);
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_rdy", 32'(in_ready), 32'd0);
        chk("mrst_full", 32'(full), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        cyc(3);
        chk("mrst_nowrite", 32'(log_a.size()), 32'd0);

        // Random traffic against the model
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 800; k++) begin
            in_valid = ($urandom % 4) != 0;
            mem_ready = ($urandom % 4) != 0;
            start = ($urandom % 40) == 0;
            stop = ($urandom % 50) == 0;
            rand_fields();
            cyc();
        end
        in_valid = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
